// File: rtl/debug_sequencer_pkg.sv
// Shared widths, command codes and state encodings for the debug run-control block.
package debug_sequencer_pkg;

    localparam int unsigned NB_DATA    = 32;
    localparam int unsigned NB_ADDR    = 5;
    localparam int unsigned N_REGS     = 32;
    localparam int unsigned CNT_W      = $clog2(N_REGS);
    localparam int unsigned DUMP_WORDS = N_REGS + 1;

    typedef enum logic [1:0] {
        CMD_RUN  = 2'b00,
        CMD_STEP = 2'b01,
        CMD_DUMP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_DUMP_PC  = 3'd3,
        ST_DUMP_REG = 3'd4,
        ST_HALTED   = 3'd5
    } state_e;

endpackage

// File: rtl/debug_sequencer_if.sv
// Command handshake and dump word stream between the host and the debug sequencer.
interface debug_sequencer_if;
    import debug_sequencer_pkg::*;

    logic               cmd_valid;
    cmd_e               cmd;
    logic               cmd_ready;
    logic               tx_valid;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_ready;

    modport master (
        output cmd_valid, cmd, tx_ready,
        input  cmd_ready, tx_valid, tx_data
    );

    modport slave (
        input  cmd_valid, cmd, tx_ready,
        output cmd_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/debug_sequencer_dump_counter.sv
// Register index counter for the dump: enable/clear with a terminal-count flag.
module debug_sequencer_dump_counter
    import debug_sequencer_pkg::*;
#(
    parameter int unsigned W    = CNT_W,
    parameter int unsigned LAST = N_REGS - 1
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_en) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

    assign o_tc = (o_cnt == W'(LAST));

endmodule

// File: rtl/debug_sequencer.sv
// Debug run-control: free-run/single-step pipeline gating, HALT detection and
// PC + register file dump over a valid/ready word stream.
module debug_sequencer
    import debug_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst_n,
    debug_sequencer_if.slave   bus,
    input  logic               i_halt_instr,
    input  logic [NB_DATA-1:0] i_pc,
    output logic               o_pipe_enable,
    output logic               o_dbg_rd_sel,
    output logic [NB_ADDR-1:0] o_dbg_rd_addr,
    input  logic [NB_DATA-1:0] i_dbg_rd_data,
    input  logic [NB_ADDR-1:0] i_dec_rs,
    output logic [NB_ADDR-1:0] o_rf_rd_addr1_c,
    output logic               o_done,
    output logic [2:0]         o_state
);

    state_e             state_q;
    state_e             ret_q;
    logic [NB_DATA-1:0] pc_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               cmd_fire;
    logic               xfer;
    logic               cnt_en;
    logic               cnt_clr;

    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign xfer     = bus.tx_valid && bus.tx_ready;
    assign cnt_en   = (state_q == ST_DUMP_REG) && xfer;
    assign cnt_clr  = ((state_q == ST_DUMP_PC) && xfer) || (cnt_en && cnt_tc);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        unique case (bus.cmd)
                            CMD_RUN:  state_q <= ST_RUN;
                            CMD_STEP: state_q <= ST_STEP;
                            CMD_DUMP: begin
                                state_q <= ST_DUMP_PC;
                                pc_q    <= i_pc;
                                ret_q   <= ST_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // Retired HALT and a HALT command collapse into one transition.
                    if (i_halt_instr || (cmd_fire && bus.cmd == CMD_HALT)) begin
                        state_q <= ST_HALTED;
                    end
                end
                ST_STEP: begin
                    state_q <= i_halt_instr ? ST_HALTED : ST_IDLE;
                end
                ST_HALTED: begin
                    if (cmd_fire && bus.cmd == CMD_DUMP) begin
                        state_q <= ST_DUMP_PC;
                        pc_q    <= i_pc;
                        ret_q   <= ST_HALTED;
                    end
                end
                ST_DUMP_PC: begin
                    if (xfer) begin
                        state_q <= ST_DUMP_REG;
                    end
                end
                ST_DUMP_REG: begin
                    if (xfer && cnt_tc) begin
                        state_q <= ret_q;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    debug_sequencer_dump_counter #(
        .W    (CNT_W),
        .LAST (N_REGS - 1)
    ) u_dump_counter (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_en    (cnt_en),
        .i_clr   (cnt_clr),
        .o_cnt   (cnt),
        .o_tc    (cnt_tc)
    );

    // Moore decode of the registered state.
    assign bus.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign o_pipe_enable = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_dbg_rd_sel  = (state_q == ST_DUMP_REG);
    assign bus.tx_valid  = (state_q == ST_DUMP_PC) || (state_q == ST_DUMP_REG);
    assign o_dbg_rd_addr = o_dbg_rd_sel ? NB_ADDR'(cnt) : '0;
    assign o_done        = done_q;
    assign o_state       = state_q;

    always_comb begin
        bus.tx_data = '0;
        if (state_q == ST_DUMP_PC) begin
            bus.tx_data = pc_q;
        end else if (state_q == ST_DUMP_REG) begin
            bus.tx_data = i_dbg_rd_data;
        end
    end

    // Register file read port 1 is borrowed from decode while dumping.
    assign o_rf_rd_addr1_c = o_dbg_rd_sel ? o_dbg_rd_addr : i_dec_rs;

endmodule

// File: tb/tb_debug_sequencer.sv
// Self-checking bench for debug_sequencer: vector table, directed corner cases and
// randomized run/step/dump trials against a transaction-level expectation model.
module tb_debug_sequencer;
    import debug_sequencer_pkg::*;

    logic               clk;
    logic               i_rst_n;
    logic               i_halt_instr;
    logic [NB_DATA-1:0] i_pc;
    logic               o_pipe_enable;
    logic               o_dbg_rd_sel;
    logic [NB_ADDR-1:0] o_dbg_rd_addr;
    logic [NB_DATA-1:0] i_dbg_rd_data;
    logic [NB_ADDR-1:0] i_dec_rs;
    logic [NB_ADDR-1:0] o_rf_rd_addr1_c;
    logic               o_done;
    logic [2:0]         o_state;

    debug_sequencer_if bus ();

    debug_sequencer dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .bus             (bus.slave),
        .i_halt_instr    (i_halt_instr),
        .i_pc            (i_pc),
        .o_pipe_enable   (o_pipe_enable),
        .o_dbg_rd_sel    (o_dbg_rd_sel),
        .o_dbg_rd_addr   (o_dbg_rd_addr),
        .i_dbg_rd_data   (i_dbg_rd_data),
        .i_dec_rs        (i_dec_rs),
        .o_rf_rd_addr1_c (o_rf_rd_addr1_c),
        .o_done          (o_done),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with asynchronous read on port 1.
    logic [NB_DATA-1:0] regs [N_REGS];
    always_comb i_dbg_rd_data = regs[o_rf_rd_addr1_c];

    int n_vec = 0;
    int n_err = 0;
    int pe_cnt = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        if (o_pipe_enable) pe_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input cmd_e c);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.tx_ready  = 1'b0;
        i_halt_instr  = 1'b0;
        i_rst_n       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic fill_regs(input bit rnd);
        for (int k = 0; k < int'(N_REGS); k++)
            regs[k] = rnd ? $urandom : 32'(k * 4);
    endtask

    // Full dump; mode 0 = always ready, 1 = toggling ready, 2 = random ready.
    task automatic run_dump(input logic [31:0] pc, input int mode, input logic [2:0] exp_ret);
        logic [31:0] words [$];
        logic [31:0] held_data;
        bit          held;
        bit          done_early;
        int          idx;
        int          cyc;
        words.delete();
        words.push_back(pc);
        for (int k = 0; k < int'(N_REGS); k++) words.push_back(regs[k]);
        i_pc = pc;
        send_cmd(CMD_DUMP);
        i_pc = $urandom;
        idx = 0; cyc = 0; held = 0; done_early = 0; held_data = '0;
        while (idx < int'(DUMP_WORDS) && cyc < 500) begin
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = (cyc % 2 == 0);
                default: bus.tx_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (o_done) done_early = 1;
            if (held) chk("dump_hold_data", bus.tx_data, held_data);
            if (bus.tx_ready) begin
                chk($sformatf("dump_word%0d", idx), {bus.tx_valid, bus.tx_data} , {1'b1, words[idx]});
                idx++;
                held = 0;
            end else begin
                held = 1;
                held_data = bus.tx_data;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.tx_ready = 1'b0;
        chk("dump_word_count", 32'(idx), 32'(DUMP_WORDS));
        if (mode == 0) chk("dump_min_cycles", 32'(cyc), 32'(DUMP_WORDS));
        chk("dump_done_early", 32'(done_early), 32'd0);
        chk("dump_done_pulse", 32'(o_done), 32'd1);
        chk("dump_ret_state", 32'(o_state), 32'(exp_ret));
        chk("dump_tx_valid_off", 32'(bus.tx_valid), 32'd0);
        tick();
        chk("dump_done_clear", 32'(o_done), 32'd0);
    endtask

    task automatic step_burst(input int n);
        pe_cnt = 0;
        for (int s = 0; s < n; s++) begin
            send_cmd(CMD_STEP);
            chk("step_state", 32'(o_state), 32'(ST_STEP));
            tick();
            chk("step_back_idle", 32'(o_state), 32'(ST_IDLE));
            repeat ($urandom_range(0, 3)) tick();
        end
        chk("step_pe_cycles", 32'(pe_cnt), 32'(n));
    endtask

    // RUN for k cycles ending by a retired HALT (use_cmd=0) or a HALT command.
    task automatic run_halt(input int k, input bit use_cmd);
        cmd_e junk [3];
        junk[0] = CMD_RUN; junk[1] = CMD_STEP; junk[2] = CMD_DUMP;
        pe_cnt = 0;
        send_cmd(CMD_RUN);
        for (int c = 1; c <= k; c++) begin
            if (c == k) begin
                if (use_cmd) begin bus.cmd_valid = 1'b1; bus.cmd = CMD_HALT; end
                else i_halt_instr = 1'b1;
            end else begin
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd       = junk[$urandom_range(0, 2)];
            end
            tick();
            bus.cmd_valid = 1'b0;
            i_halt_instr  = 1'b0;
        end
        tick();
        tick();
        chk("run_pe_cycles", 32'(pe_cnt), 32'(k));
        chk("run_halted", 32'(o_state), 32'(ST_HALTED));
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        cmd_e       cmd;
        logic       halt;
        logic [2:0] st;
        logic       rdy;
        logic       pe;
        logic       tv;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [2:0] where;
        bus.cmd_valid = 1'b0;
        bus.cmd       = CMD_RUN;
        bus.tx_ready  = 1'b0;
        i_halt_instr  = 1'b0;
        i_pc          = '0;
        i_dec_rs      = '0;
        i_rst_n       = 1'b0;
        fill_regs(0);

        // Reset state while reset is held.
        #12;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_outputs", {o_pipe_enable, o_dbg_rd_sel, bus.tx_valid, o_done},
            32'd0);
        chk("rst_data", {bus.tx_data}, 32'd0);
        chk("rst_rd_addr", 32'(o_dbg_rd_addr), 32'd0);
        do_reset();

        tbl[0]  = '{1'b1, 1'b1, CMD_HALT, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, CMD_RUN,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, CMD_STEP, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, CMD_RUN,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, CMD_RUN,  1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, CMD_STEP, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, CMD_DUMP, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, CMD_RUN,  1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, CMD_RUN,  1'b0, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, CMD_STEP, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, CMD_HALT, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, CMD_RUN,  1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, CMD_STEP, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, CMD_RUN,  1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, CMD_DUMP, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, CMD_RUN,  1'b0, 3'd3, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            bus.cmd_valid = tbl[i].vld;
            bus.cmd       = tbl[i].cmd;
            i_halt_instr  = tbl[i].halt;
            i_dec_rs      = NB_ADDR'($urandom);
            @(negedge clk);
            chk($sformatf("vec%0d_rs_mux", i), 32'(o_rf_rd_addr1_c), 32'(i_dec_rs));
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            i_halt_instr  = 1'b0;
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_flags", i),
                {29'd0, bus.cmd_ready, o_pipe_enable, bus.tx_valid},
                {29'd0, tbl[i].rdy, tbl[i].pe, tbl[i].tv});
        end

        // RUN with retired HALT in cycle 10: enable high cycles 1..10.
        do_reset();
        send_cmd(CMD_RUN);
        for (int c = 1; c <= 12; c++) begin
            i_halt_instr = (c == 10);
            @(negedge clk);
            chk($sformatf("run10_pe_c%0d", c), 32'(o_pipe_enable), 32'(c <= 10));
            @(posedge clk);
            #1;
        end
        i_halt_instr = 1'b0;
        chk("run10_halted", 32'(o_state), 32'd5);

        // Simultaneous retired HALT and HALT command.
        do_reset();
        send_cmd(CMD_RUN);
        tick();
        bus.cmd_valid = 1'b1; bus.cmd = CMD_HALT; i_halt_instr = 1'b1;
        @(negedge clk);
        chk("simul_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0; i_halt_instr = 1'b0;
        chk("simul_halted", 32'(o_state), 32'd5);
        chk("simul_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Three STEPs with gaps, then dump from HALTED with Rk = k*4.
        do_reset();
        step_burst(3);
        run_halt(4, 0);
        fill_regs(0);
        run_dump(32'h0000_0040, 0, 3'd5);
        run_dump(32'h0000_0040, 1, 3'd5);

        // Reset while word 12 of a dump is presented.
        do_reset();
        fill_regs(0);
        i_pc = 32'h0000_0100;
        bus.tx_ready = 1'b1;
        send_cmd(CMD_DUMP);
        for (int w = 0; w < 12; w++) begin
            @(negedge clk);
            chk($sformatf("abort_word%0d", w), bus.tx_data,
                (w == 0) ? 32'h100 : 32'((w - 1) * 4));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("abort_state", 32'(o_state), 32'd0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        begin
            bit done_seen;
            done_seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (o_done) done_seen = 1;
                @(posedge clk);
                #1;
            end
            chk("abort_no_done", 32'(done_seen), 32'd0);
        end
        bus.tx_ready = 1'b0;
        run_dump(32'h0000_0200, 0, 3'd0);

        // Randomized trials; the model only tracks IDLE vs HALTED between trials.
        where = 3'd0;
        for (int t = 0; t < 24; t++) begin
            int sc;
            sc = $urandom_range(0, 2);
            if (sc != 2 && where == 3'd5) begin
                do_reset();
                where = 3'd0;
            end
            case (sc)
                0: step_burst($urandom_range(1, 5));
                1: begin
                    run_halt($urandom_range(1, 20), 1'($urandom_range(0, 1)));
                    where = 3'd5;
                end
                default: begin
                    fill_regs(1);
                    run_dump($urandom, 2, where);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
